ct_mult_sched: RTL and testbench

- Sequencer for ciphertext-ciphertext multiplication on one shared modular multiplier (mult followed by mod_vector, outside this block).
- Accepts one ciphertext pair (CT_t). Issues the four coefficient-wise products in order:
  - D0 = B1·B2
  - D1 = A1·A2
  - D2A = A1·B2
  - D2B = B1·A2
- Captures the reduced results and forms D2 = (D2A + D2B) mod Q.
- Streams the gadget decomposition of D2, one digit vector per handshake. Then presents D0/D1/D2 until the consumer accepts them.

---
 rtl/ct_mult_sched_pkg.sv | 39 +++
 rtl/ct_mult_sched_if.sv | 41 ++++
 rtl/ct_mult_sched_digit_extract.sv | 24 ++
 rtl/ct_mult_sched.sv | 162 ++++++++++++++++
 tb/tb_ct_mult_sched.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ct_mult_sched_pkg.sv
// rtl/ct_mult_sched_pkg.sv - shared types and constants for the ciphertext multiply sequencer
package ct_mult_sched_pkg;

    localparam int N_COEF          = 4;
    localparam int WORD_W          = 7;
    localparam int Q               = 97;
    localparam int BASE            = 4;
    localparam int DEF_LOG_BASE    = $clog2(BASE);
    localparam int DEF_NUM_DIGITS  = 4;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [WORD_W:0]     wide_word_t;
    typedef word_t      [N_COEF-1:0] vec_t;
    typedef wide_word_t [N_COEF-1:0] wide_vec_t;

    typedef struct packed {
        vec_t a;
        vec_t b;
    } ct_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DECOMP,
        S_DONE
    } state_t;

    // Both operands are already < Q, so one conditional subtract reduces the sum.
    function automatic word_t add_mod(input word_t x, input word_t y);
        wide_word_t s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= wide_word_t'(Q)) begin
            s = s - wide_word_t'(Q);
        end
        return s[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/ct_mult_sched_if.sv
// rtl/ct_mult_sched_if.sv - handshake and data bundle between the sequencer and its environment
interface ct_mult_sched_if
    import ct_mult_sched_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic             in_valid;
    logic             in_ready;
    ct_t              in_ct1;
    ct_t              in_ct2;
    logic             mm_valid;
    vec_t             mm_a;
    vec_t             mm_b;
    logic             mm_res_valid;
    vec_t             mm_res;
    logic             dig_valid;
    logic             dig_ready;
    logic [IDX_W-1:0] dig_idx;
    vec_t             dig_vec;
    logic             out_valid;
    logic             out_ready;
    vec_t             out_d0;
    vec_t             out_d1;
    vec_t             out_d2;
    logic             busy;

    modport master (
        input  in_valid, in_ct1, in_ct2, mm_res_valid, mm_res, dig_ready, out_ready,
        output in_ready, mm_valid, mm_a, mm_b, dig_valid, dig_idx, dig_vec,
               out_valid, out_d0, out_d1, out_d2, busy
    );

    modport slave (
        output in_valid, in_ct1, in_ct2, mm_res_valid, mm_res, dig_ready, out_ready,
        input  in_ready, mm_valid, mm_a, mm_b, dig_valid, dig_idx, dig_vec,
               out_valid, out_d0, out_d1, out_d2, busy
    );

endinterface

// File: rtl/ct_mult_sched_digit_extract.sv
// rtl/ct_mult_sched_digit_extract.sv - per-coefficient gadget digit select (shift and mask)
module digit_extract
    import ct_mult_sched_pkg::*;
#(
    parameter int LOG_BASE = DEF_LOG_BASE,
    parameter int IDX_W    = 2
) (
    input  vec_t             vec,
    input  logic [IDX_W-1:0] idx,
    output vec_t             digits
);
    localparam word_t MASK = word_t'((1 << LOG_BASE) - 1);

    logic [31:0] shamt;

    always_comb begin
        shamt  = 32'(idx) * 32'(LOG_BASE);
        digits = '0;
        for (int i = 0; i < N_COEF; i++) begin
            digits[i] = (vec[i] >> shamt) & MASK;
        end
    end

endmodule

// File: rtl/ct_mult_sched.sv
// rtl/ct_mult_sched.sv - sequences one CT x CT product over a shared modular multiplier
module ct_mult_sched
    import ct_mult_sched_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int LOG_BASE   = DEF_LOG_BASE
) (
    input  logic            clk,
    input  logic            rst_n,
    ct_mult_sched_if.master bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t           state;
    state_t           state_nx;
    ct_t              ct1_q;
    ct_t              ct2_q;
    logic [1:0]       iss_cnt;
    logic [2:0]       ret_cnt;
    logic [IDX_W-1:0] idx_q;
    vec_t             d0_q;
    vec_t             d1_q;
    vec_t             ta_q;
    vec_t             d2_q;
    vec_t             d2_mod;
    vec_t             dig_vec_w;
    logic             capture;
    logic             ret_last;
    logic             to_idle;

    // Returns are only meaningful while an operation is collecting its four products.
    assign capture  = ((state == S_ISSUE) || (state == S_WAIT)) && bus.mm_res_valid
                      && (ret_cnt != 3'd4);
    assign ret_last = (capture && (ret_cnt == 3'd3)) || (ret_cnt == 3'd4);
    assign to_idle  = (state == S_DONE) && bus.out_ready;

    always_comb begin
        d2_mod = '0;
        for (int i = 0; i < N_COEF; i++) begin
            d2_mod[i] = add_mod(ta_q[i], bus.mm_res[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ct1_q   <= '0;
            ct2_q   <= '0;
            iss_cnt <= '0;
            ret_cnt <= '0;
            idx_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            ta_q    <= '0;
            d2_q    <= '0;
        end else begin
            state <= state_nx;
            if ((state == S_IDLE) && bus.in_valid) begin
                ct1_q <= bus.in_ct1;
                ct2_q <= bus.in_ct2;
            end
            if ((state == S_ISSUE) && (iss_cnt != 2'd3)) begin
                iss_cnt <= iss_cnt + 2'd1;
            end
            if (capture) begin
                case (ret_cnt[1:0])
                    2'd0:    d0_q <= bus.mm_res;
                    2'd1:    d1_q <= bus.mm_res;
                    2'd2:    ta_q <= bus.mm_res;
                    default: d2_q <= d2_mod;
                endcase
                ret_cnt <= ret_cnt + 3'd1;
            end
            if ((state == S_DECOMP) && bus.dig_ready
                && (idx_q != IDX_W'(NUM_DIGITS - 1))) begin
                idx_q <= idx_q + 1'b1;
            end
            if (to_idle) begin
                iss_cnt <= '0;
                ret_cnt <= '0;
                idx_q   <= '0;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.mm_valid  = 1'b0;
        bus.mm_a      = '0;
        bus.mm_b      = '0;
        bus.dig_valid = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.mm_valid = 1'b1;
                case (iss_cnt)
                    2'd0: begin
                        bus.mm_a = ct1_q.b;
                        bus.mm_b = ct2_q.b;
                    end
                    2'd1: begin
                        bus.mm_a = ct1_q.a;
                        bus.mm_b = ct2_q.a;
                    end
                    2'd2: begin
                        bus.mm_a = ct1_q.a;
                        bus.mm_b = ct2_q.b;
                    end
                    default: begin
                        bus.mm_a = ct1_q.b;
                        bus.mm_b = ct2_q.a;
                    end
                endcase
                if (iss_cnt == 2'd3) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ret_last) begin
                    state_nx = S_DECOMP;
                end
            end
            S_DECOMP: begin
                bus.dig_valid = 1'b1;
                if (bus.dig_ready && (idx_q == IDX_W'(NUM_DIGITS - 1))) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    digit_extract #(
        .LOG_BASE (LOG_BASE),
        .IDX_W    (IDX_W)
    ) u_digit_extract (
        .vec    (d2_q),
        .idx    (idx_q),
        .digits (dig_vec_w)
    );

    assign bus.dig_idx = idx_q;
    assign bus.dig_vec = dig_vec_w;
    assign bus.out_d0  = d0_q;
    assign bus.out_d1  = d1_q;
    assign bus.out_d2  = d2_q;
    assign bus.busy    = (state != S_IDLE);

endmodule

// File: tb/tb_ct_mult_sched.sv
// tb/tb_ct_mult_sched.sv - self-checking bench for ct_mult_sched with a behavioural multiplier
module tb_ct_mult_sched;
    import ct_mult_sched_pkg::*;

    localparam int ND = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   cyc;
    int   lat_cfg;

    vec_t q_res[$];
    int   q_due[$];
    vec_t iss_a[$];
    vec_t iss_b[$];
    int   iss_cyc[$];

    ct_mult_sched_if #(.NUM_DIGITS(ND)) bus ();

    ct_mult_sched #(
        .NUM_DIGITS (ND),
        .LOG_BASE   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t splat(input int v);
        vec_t r;
        for (int i = 0; i < N_COEF; i++) r[i] = word_t'(v);
        return r;
    endfunction

    function automatic vec_t mulv(input vec_t x, input vec_t y);
        vec_t r;
        for (int i = 0; i < N_COEF; i++) r[i] = word_t'((int'(x[i]) * int'(y[i])) % Q);
        return r;
    endfunction

    function automatic vec_t addv(input vec_t x, input vec_t y);
        vec_t r;
        for (int i = 0; i < N_COEF; i++) r[i] = word_t'((int'(x[i]) + int'(y[i])) % Q);
        return r;
    endfunction

    function automatic vec_t digv(input vec_t d, input int k);
        vec_t r;
        for (int i = 0; i < N_COEF; i++) r[i] = word_t'((int'(d[i]) / (BASE ** k)) % BASE);
        return r;
    endfunction

    // Fully pipelined external multiplier: result of an issue in cycle c returns in cycle c+lat.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_res.delete();
            q_due.delete();
            bus.mm_res_valid = 1'b0;
            bus.mm_res       = '0;
        end else begin
            bus.mm_res_valid = 1'b0;
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                bus.mm_res_valid = 1'b1;
                bus.mm_res       = q_res.pop_front();
                void'(q_due.pop_front());
            end
            if (bus.mm_valid) begin
                q_res.push_back(mulv(bus.mm_a, bus.mm_b));
                q_due.push_back(cyc + lat_cfg);
                iss_a.push_back(bus.mm_a);
                iss_b.push_back(bus.mm_b);
                iss_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input vec_t a1, input vec_t b1, input vec_t a2,
                          input vec_t b2, input vec_t e0, input vec_t e1, input vec_t e2,
                          input int lat, input int sidx, input int sn, input int ostall);
        vec_t ea[4];
        vec_t eb[4];
        int   n;
        ea = '{b1, a1, a1, b1};
        eb = '{b2, a2, b2, a2};
        lat_cfg = lat;
        iss_a.delete();
        iss_b.delete();
        iss_cyc.delete();
        chk(tag, "idle_in_ready", bus.in_ready, 1);
        chk(tag, "idle_busy", bus.busy, 0);
        bus.in_ct1.a = a1;
        bus.in_ct1.b = b1;
        bus.in_ct2.a = a2;
        bus.in_ct2.b = b2;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_ct1   = ct_t'({$urandom, $urandom});
        bus.in_ct2   = ct_t'({$urandom, $urandom});
        chk(tag, "busy_after_accept", bus.busy, 1);
        chk(tag, "in_ready_busy", bus.in_ready, 0);
        n = 0;
        while (!bus.dig_valid && n < 64) begin
            bus.in_valid = (n == 2);
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        chk(tag, "dig_valid_timeout", bus.dig_valid, 1);
        if (!bus.dig_valid) return;
        for (int k = 0; k < ND; k++) begin
            if (k == sidx) begin
                for (int s = 0; s < sn; s++) begin
                    bus.in_valid = 1'b1;
                    @(negedge clk);
                    chk(tag, "hold_dig_idx", bus.dig_idx, k);
                    chk(tag, "hold_dig_vec", bus.dig_vec, digv(e2, k));
                    chk(tag, "hold_in_ready", bus.in_ready, 0);
                end
                bus.in_valid = 1'b0;
            end
            chk(tag, "dig_valid", bus.dig_valid, 1);
            chk(tag, "dig_idx", bus.dig_idx, k);
            chk(tag, "dig_vec", bus.dig_vec, digv(e2, k));
            bus.dig_ready = 1'b1;
            @(negedge clk);
            bus.dig_ready = 1'b0;
        end
        chk(tag, "out_valid", bus.out_valid, 1);
        chk(tag, "dig_valid_done", bus.dig_valid, 0);
        for (int s = 0; s < ostall; s++) begin
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk(tag, "hold_out_valid", bus.out_valid, 1);
            chk(tag, "hold_out_d2", bus.out_d2, e2);
            chk(tag, "hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        chk(tag, "out_d0", bus.out_d0, e0);
        chk(tag, "out_d1", bus.out_d1, e1);
        chk(tag, "out_d2", bus.out_d2, e2);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk(tag, "out_valid_clear", bus.out_valid, 0);
        chk(tag, "back_idle_in_ready", bus.in_ready, 1);
        chk(tag, "back_idle_busy", bus.busy, 0);
        chk(tag, "issue_count", iss_a.size(), 4);
        if (iss_a.size() == 4) begin
            chk(tag, "issue_consecutive", iss_cyc[3] - iss_cyc[0], 3);
            for (int p = 0; p < 4; p++) begin
                chk(tag, $sformatf("op%0d_a", p), iss_a[p], ea[p]);
                chk(tag, $sformatf("op%0d_b", p), iss_b[p], eb[p]);
            end
        end
    endtask

    typedef struct {
        int a1, b1, a2, b2;
        int lat, sidx, sn, ostall;
        int e0, e1, e2;
    } rec_t;

    rec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors            = 0;
        checks            = 0;
        cyc               = 0;
        lat_cfg           = 3;
        rst_n             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_ct1        = '0;
        bus.in_ct2        = '0;
        bus.dig_ready     = 1'b0;
        bus.out_ready     = 1'b0;

        tbl[0] = '{3, 5, 7, 11, 3, -1, 0, 0, 55, 21, 68};
        tbl[1] = '{60, 50, 1, 1, 3, -1, 0, 0, 50, 60, 13};
        tbl[2] = '{96, 96, 96, 96, 3, -1, 0, 0, 1, 1, 2};
        tbl[3] = '{3, 5, 7, 11, 3, 1, 3, 5, 55, 21, 68};
        tbl[4] = '{3, 5, 7, 11, 1, -1, 0, 0, 55, 21, 68};
        tbl[5] = '{3, 5, 7, 11, 8, -1, 0, 0, 55, 21, 68};

        repeat (3) @(negedge clk);
        chk("reset", "in_ready", bus.in_ready, 1);
        chk("reset", "busy", bus.busy, 0);
        chk("reset", "mm_valid", bus.mm_valid, 0);
        chk("reset", "dig_valid", bus.dig_valid, 0);
        chk("reset", "out_valid", bus.out_valid, 0);
        chk("reset", "out_d2", bus.out_d2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            run_op($sformatf("t%0d", r), splat(tbl[r].a1), splat(tbl[r].b1), splat(tbl[r].a2),
                   splat(tbl[r].b2), splat(tbl[r].e0), splat(tbl[r].e1), splat(tbl[r].e2),
                   tbl[r].lat, tbl[r].sidx, tbl[r].sn, tbl[r].ostall);
        end

        // Asynchronous reset in WAIT after two of four returns, then a clean operation.
        lat_cfg = 3;
        bus.in_ct1.a = splat(60);
        bus.in_ct1.b = splat(50);
        bus.in_ct2.a = splat(1);
        bus.in_ct2.b = splat(1);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst", "pre_busy", bus.busy, 1);
        chk("rst", "pre_mm_valid", bus.mm_valid, 0);
        chk("rst", "pre_dig_valid", bus.dig_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("rst", "busy", bus.busy, 0);
        chk("rst", "in_ready", bus.in_ready, 1);
        chk("rst", "out_valid", bus.out_valid, 0);
        chk("rst", "out_d0", bus.out_d0, 0);
        chk("rst", "out_d1", bus.out_d1, 0);
        chk("rst", "dig_idx", bus.dig_idx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst", splat(3), splat(5), splat(7), splat(11),
               splat(55), splat(21), splat(68), 3, -1, 0, 0);

        for (int r = 0; r < 8; r++) begin
            vec_t a1, b1, a2, b2;
            for (int i = 0; i < N_COEF; i++) begin
                a1[i] = word_t'($urandom_range(0, Q - 1));
                b1[i] = word_t'($urandom_range(0, Q - 1));
                a2[i] = word_t'($urandom_range(0, Q - 1));
                b2[i] = word_t'($urandom_range(0, Q - 1));
            end
            run_op($sformatf("rnd%0d", r), a1, b1, a2, b2, mulv(b1, b2), mulv(a1, a2),
                   addv(mulv(a1, b2), mulv(b1, a2)), int'($urandom_range(1, 8)),
                   int'($urandom_range(0, ND - 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
